// File: rtl/tlc_timed_nway.sv
// rtl/tlc_timed_nway.sv - N-way timed traffic light controller with emergency pre-emption
module tlc_timed_nway #(
  parameter int N_DIR      = 4,
  parameter int DIR_W      = 2,
  parameter int CNT_W      = 8,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               emg,
  input  logic [DIR_W-1:0]   emg_dir,
  output logic [3*N_DIR-1:0] TL,
  output logic [DIR_W-1:0]   cur_dir,
  output logic [1:0]         phase,
  output logic               emg_act
);

  localparam logic [1:0] PH_GREEN  = 2'b00;
  localparam logic [1:0] PH_YELLOW = 2'b01;
  localparam logic [1:0] PH_ALLRED = 2'b10;

  // Counter holds remaining cycles minus one; the phase advances when it reads zero.
  localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] Y_LOAD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] A_LOAD = CNT_W'((ALLRED_CYC > 0) ? ALLRED_CYC - 1 : 0);
  // On release the releasing cycle already counts as the first of the fresh green dwell.
  localparam logic [CNT_W-1:0] G_REL  = CNT_W'((GREEN_CYC > 1) ? GREEN_CYC - 2 : 0);

  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [DIR_W-1:0] target, nxt_target, nxt_dir, succ_dir, nxt_green_dir;
  logic [1:0]       nxt_phase;
  logic             nxt_act;

  function automatic logic [3*N_DIR-1:0] tl_of(input logic [1:0] ph, input logic [DIR_W-1:0] dir);
    logic [3*N_DIR-1:0] t;
    t = '0;
    for (int d = 0; d < N_DIR; d++) begin
      t[3*d +: 3] = 3'b100;
      if (DIR_W'(d) == dir) begin
        if (ph == PH_GREEN)  t[3*d +: 3] = 3'b001;
        if (ph == PH_YELLOW) t[3*d +: 3] = 3'b010;
      end
    end
    return t;
  endfunction

  assign succ_dir      = (cur_dir == DIR_W'(N_DIR - 1)) ? '0 : cur_dir + 1'b1;
  assign nxt_green_dir = emg_act ? target : succ_dir;

  always_comb begin
    nxt_dir    = cur_dir;
    nxt_phase  = phase;
    nxt_cnt    = cnt - 1'b1;
    nxt_act    = emg_act;
    nxt_target = target;

    if (!emg_act && emg) begin
      nxt_act    = 1'b1;
      nxt_target = ({1'b0, emg_dir} < (DIR_W+1)'(N_DIR)) ? emg_dir : '0;
    end

    case (phase)
      PH_GREEN: begin
        if (emg_act && cur_dir != target) begin
          nxt_phase = PH_YELLOW;
          nxt_cnt   = Y_LOAD;
        end else if (emg_act && emg) begin
          nxt_cnt = cnt;
        end else if (emg_act) begin
          nxt_act = 1'b0;
          if (GREEN_CYC == 1) begin
            nxt_phase = PH_YELLOW;
            nxt_cnt   = Y_LOAD;
          end else begin
            nxt_cnt = G_REL;
          end
        end else if (cnt == '0) begin
          nxt_phase = PH_YELLOW;
          nxt_cnt   = Y_LOAD;
        end
      end
      PH_YELLOW: begin
        if (cnt == '0) begin
          if (ALLRED_CYC > 0) begin
            nxt_phase = PH_ALLRED;
            nxt_cnt   = A_LOAD;
          end else begin
            nxt_phase = PH_GREEN;
            nxt_dir   = nxt_green_dir;
            nxt_cnt   = G_LOAD;
          end
        end
      end
      PH_ALLRED: begin
        if (cnt == '0) begin
          nxt_phase = PH_GREEN;
          nxt_dir   = nxt_green_dir;
          nxt_cnt   = G_LOAD;
        end
      end
      default: begin
        nxt_phase = PH_GREEN;
        nxt_dir   = '0;
        nxt_cnt   = G_LOAD;
        nxt_act   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_dir <= '0;
      phase   <= PH_GREEN;
      cnt     <= G_LOAD;
      emg_act <= 1'b0;
      target  <= '0;
      TL      <= tl_of(PH_GREEN, '0);
    end else begin
      cur_dir <= nxt_dir;
      phase   <= nxt_phase;
      cnt     <= nxt_cnt;
      emg_act <= nxt_act;
      target  <= nxt_target;
      TL      <= tl_of(nxt_phase, nxt_dir);
    end
  end

endmodule
